ex_mem_pipe_reg: RTL and testbench

Parametrised EX/MEM pipeline register, the successor to the fixed two-phase EX/MEM latch. All state updates on the rising edge only. Adds a valid/ready handshake with a two-entry skid buffer, so the memory stage can back-pressure without a combinational ready path. Adds a flush, bubble-safe control gating and configurable field widths. Sits between the ALU/forwarding logic of EX and the data-memory/WB path.

---
 rtl/cpu_pipe_pkg.sv | 29 ++
 rtl/ex_mem_pipe_reg_if.sv | 52 +++++
 rtl/pipe_skid_buf.sv | 88 ++++++++
 rtl/ex_mem_pipe_reg.sv | 83 ++++++++
 tb/tb_ex_mem_pipe_reg.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: default field widths, control-bit positions
// and the EX/MEM payload layout used by the pipeline registers.
package cpu_pipe_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int RADDR_W_DEF = 5;
  localparam int WB_W_DEF    = 2;
  localparam int MEM_W_DEF   = 2;

  localparam int MEM_WRITE_BIT   = 1;
  localparam int MEM_READ_BIT    = 0;
  localparam int WB_REGWRITE_BIT = 1;
  localparam int WB_MEMTOREG_BIT = 0;

  // EX/MEM payload at the default widths; field order matches the packing
  // done inside ex_mem_pipe_reg (wb is the most significant field).
  typedef struct packed {
    logic [WB_W_DEF-1:0]    wb;
    logic [MEM_W_DEF-1:0]   mem;
    logic [DATA_W_DEF-1:0]  alu_out;
    logic [DATA_W_DEF-1:0]  mem_wdata;
    logic [RADDR_W_DEF-1:0] rd_addr;
  } ex_mem_payload_t;

  function automatic int ex_mem_payload_w(int data_w, int raddr_w, int wb_w, int mem_w);
    return wb_w + mem_w + 2 * data_w + raddr_w;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_reg_if.sv
// EX/MEM bus: EX-side handshake and payload in, MEM-side handshake and
// held payload out. Forwarding taps exist only when EX_MEM_FWD_EN is defined.
interface ex_mem_pipe_reg_if
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int WB_W    = WB_W_DEF,
  parameter int MEM_W   = MEM_W_DEF
);
  logic               valid_i;
  logic               ready_o;
  logic               flush_i;
  logic [WB_W-1:0]    wb_i;
  logic [MEM_W-1:0]   mem_i;
  logic [DATA_W-1:0]  alu_out_i;
  logic [DATA_W-1:0]  mem_wdata_i;
  logic [RADDR_W-1:0] rd_addr_i;

  logic               valid_o;
  logic               ready_i;
  logic [DATA_W-1:0]  alu_out_o;
  logic [DATA_W-1:0]  mem_wdata_o;
  logic [RADDR_W-1:0] rd_addr_o;
  logic [WB_W-1:0]    wb_o;
  logic               mem_write_o;
  logic               mem_read_o;
`ifdef EX_MEM_FWD_EN
  logic               fwd_valid_o;
  logic [RADDR_W-1:0] fwd_rd_o;
  logic [DATA_W-1:0]  fwd_data_o;
`endif

  modport master (
    output valid_i, flush_i, wb_i, mem_i, alu_out_i, mem_wdata_i, rd_addr_i, ready_i,
    input  ready_o, valid_o, alu_out_o, mem_wdata_o, rd_addr_o, wb_o,
           mem_write_o, mem_read_o
`ifdef EX_MEM_FWD_EN
    , input fwd_valid_o, fwd_rd_o, fwd_data_o
`endif
  );

  modport slave (
    input  valid_i, flush_i, wb_i, mem_i, alu_out_i, mem_wdata_i, rd_addr_i, ready_i,
    output ready_o, valid_o, alu_out_o, mem_wdata_o, rd_addr_o, wb_o,
           mem_write_o, mem_read_o
`ifdef EX_MEM_FWD_EN
    , output fwd_valid_o, fwd_rd_o, fwd_data_o
`endif
  );

endinterface

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer. The main entry drives the
// output; the skid entry catches the one transfer that arrives while the
// main entry is stalled. ready_o is a flop, so there is no combinational
// path from ready_i back to the producer. Flush empties both entries.
module pipe_skid_buf #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [PAYLOAD_W-1:0] data_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [PAYLOAD_W-1:0] data_o
);

  logic                 r_main_valid;
  logic [PAYLOAD_W-1:0] r_main_data;
  logic                 r_skid_valid;
  logic [PAYLOAD_W-1:0] r_skid_data;
  logic                 r_ready;

  logic                 w_accept;
  logic                 w_emit;
  logic                 w_main_valid_nxt;
  logic [PAYLOAD_W-1:0] w_main_data_nxt;
  logic                 w_skid_valid_nxt;
  logic [PAYLOAD_W-1:0] w_skid_data_nxt;

  assign w_accept = valid_i & r_ready;
  assign w_emit   = r_main_valid & ready_i;

  // Next-state of both entries; skid content always moves to main before
  // any newer input so ordering is preserved.
  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_main_data_nxt  = r_main_data;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_data_nxt  = r_skid_data;
    if (!r_main_valid || w_emit) begin
      if (r_skid_valid) begin
        w_main_valid_nxt = 1'b1;
        w_main_data_nxt  = r_skid_data;
        w_skid_valid_nxt = w_accept;
        if (w_accept) begin
          w_skid_data_nxt = data_i;
        end
      end else if (w_accept) begin
        w_main_valid_nxt = 1'b1;
        w_main_data_nxt  = data_i;
      end else begin
        w_main_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      // main stalled; r_ready guarantees the skid entry is free here
      w_skid_valid_nxt = 1'b1;
      w_skid_data_nxt  = data_i;
    end
    if (flush_i) begin
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end
  end

  // Entry registers and registered ready; reset beats flush and handshake.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_ready      <= 1'b1;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_main_data  <= w_main_data_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_data  <= w_skid_data_nxt;
      r_ready      <= ~w_skid_valid_nxt;
    end
  end

  assign ready_o = r_ready;
  assign valid_o = r_main_valid;
  assign data_o  = r_main_data;

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register built on pipe_skid_buf. Packs the EX payload,
// unpacks the held entry and gates the write-back/memory controls so a
// bubble can never write memory or the register file.
// Optional forwarding taps: define EX_MEM_FWD_EN.
module ex_mem_pipe_reg
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int WB_W    = WB_W_DEF,
  parameter int MEM_W   = MEM_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  ex_mem_pipe_reg_if.slave   bus
);

  localparam int PAYLOAD_W = ex_mem_payload_w(DATA_W, RADDR_W, WB_W, MEM_W);

  typedef struct packed {
    logic [WB_W-1:0]    wb;
    logic [MEM_W-1:0]   mem;
    logic [DATA_W-1:0]  alu_out;
    logic [DATA_W-1:0]  mem_wdata;
    logic [RADDR_W-1:0] rd_addr;
  } payload_t;

  payload_t w_in;
  payload_t w_out;
  logic     w_valid;

  assign w_in.wb        = bus.wb_i;
  assign w_in.mem       = bus.mem_i;
  assign w_in.alu_out   = bus.alu_out_i;
  assign w_in.mem_wdata = bus.mem_wdata_i;
  assign w_in.rd_addr   = bus.rd_addr_i;

  pipe_skid_buf #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (bus.flush_i),
    .valid_i (bus.valid_i),
    .ready_o (bus.ready_o),
    .data_i  (w_in),
    .valid_o (w_valid),
    .ready_i (bus.ready_i),
    .data_o  (w_out)
  );

  assign bus.valid_o     = w_valid;
  assign bus.alu_out_o   = w_out.alu_out;
  assign bus.mem_wdata_o = w_out.mem_wdata;
  assign bus.rd_addr_o   = w_out.rd_addr;

  // Control outputs are zero whenever no valid entry is held.
  always_comb begin
    bus.wb_o        = '0;
    bus.mem_write_o = 1'b0;
    bus.mem_read_o  = 1'b0;
    if (w_valid) begin
      bus.wb_o        = w_out.wb;
      bus.mem_write_o = w_out.mem[MEM_WRITE_BIT];
      bus.mem_read_o  = w_out.mem[MEM_READ_BIT];
    end
  end

`ifdef EX_MEM_FWD_EN
  // Forwarding tap: only a valid register write to a non-zero rd forwards.
  always_comb begin
    bus.fwd_valid_o = 1'b0;
    bus.fwd_rd_o    = '0;
    bus.fwd_data_o  = '0;
    if (w_valid && w_out.wb[WB_REGWRITE_BIT] && (w_out.rd_addr != '0)) begin
      bus.fwd_valid_o = 1'b1;
      bus.fwd_rd_o    = w_out.rd_addr;
      bus.fwd_data_o  = w_out.alu_out;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Scoreboard bench for ex_mem_pipe_reg. The reference model is an ordered
// queue of accepted payloads holding at most two entries; the stage is
// ready whenever fewer than two are held.
module tb_ex_mem_pipe_reg;
  import cpu_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_mem_pipe_reg_if bus ();

  ex_mem_pipe_reg dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  ex_mem_payload_t exp_q[$];
  bit known      = 1'b0;
  bit post_reset = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic fl, input logic rdy,
                       input logic [1:0] wb, input logic [1:0] mem,
                       input logic [31:0] alu, input logic [4:0] rd);
    rst_n           = rst;
    bus.valid_i     = v;
    bus.flush_i     = fl;
    bus.ready_i     = rdy;
    bus.wb_i        = wb;
    bus.mem_i       = mem;
    bus.alu_out_i   = alu;
    bus.mem_wdata_i = $urandom;
    bus.rd_addr_i   = rd;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 2'b11, 32'h0, 5'd0);
  endtask

  // Monitor: compare the DUT against the model, then advance the model with
  // the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    ex_mem_payload_t f;
    bit exp_v;
    int occ;
    if (known) begin
      exp_v = (exp_q.size() > 0);
      f = exp_v ? exp_q[0] : '0;
      chk("valid_o", 32'(bus.valid_o), 32'(exp_v));
      chk("ready_o", 32'(bus.ready_o), 32'(exp_q.size() < 2));
      if (exp_v) begin
        chk("alu_out_o",   bus.alu_out_o,           f.alu_out);
        chk("mem_wdata_o", bus.mem_wdata_o,         f.mem_wdata);
        chk("rd_addr_o",   32'(bus.rd_addr_o),      32'(f.rd_addr));
        chk("wb_o",        32'(bus.wb_o),           32'(f.wb));
        chk("mem_write_o", 32'(bus.mem_write_o),    32'(f.mem[MEM_WRITE_BIT]));
        chk("mem_read_o",  32'(bus.mem_read_o),     32'(f.mem[MEM_READ_BIT]));
      end else begin
        chk("wb_o_gated",        32'(bus.wb_o),        32'h0);
        chk("mem_write_o_gated", 32'(bus.mem_write_o), 32'h0);
        chk("mem_read_o_gated",  32'(bus.mem_read_o),  32'h0);
        if (post_reset) begin
          chk("alu_out_o_rst",   bus.alu_out_o,      32'h0);
          chk("mem_wdata_o_rst", bus.mem_wdata_o,    32'h0);
          chk("rd_addr_o_rst",   32'(bus.rd_addr_o), 32'h0);
        end
      end
`ifdef EX_MEM_FWD_EN
      begin
        bit fv;
        fv = exp_v && f.wb[WB_REGWRITE_BIT] && (f.rd_addr != 5'd0);
        chk("fwd_valid_o", 32'(bus.fwd_valid_o), 32'(fv));
        chk("fwd_rd_o",    32'(bus.fwd_rd_o),    fv ? 32'(f.rd_addr) : 32'h0);
        chk("fwd_data_o",  bus.fwd_data_o,       fv ? f.alu_out : 32'h0);
      end
`endif
    end

    if (!rst_n) begin
      exp_q.delete();
      known      = 1'b1;
      post_reset = 1'b1;
    end else if (known) begin
      post_reset = 1'b0;
      occ = exp_q.size();
      if (occ > 0 && bus.ready_i) void'(exp_q.pop_front());
      if (bus.valid_i && occ < 2) begin
        ex_mem_payload_t p;
        p.wb        = bus.wb_i;
        p.mem       = bus.mem_i;
        p.alu_out   = bus.alu_out_i;
        p.mem_wdata = bus.mem_wdata_i;
        p.rd_addr   = bus.rd_addr_i;
        exp_q.push_back(p);
      end
      if (bus.flush_i) exp_q.delete();
    end
  end

  initial begin
    // reset held with valid_i high: nothing may be accepted
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 2'b11, 32'hDEAD, 5'd3);
    idle(1);

    // streaming at full rate
    drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 32'h10, 5'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 32'h20, 5'd2);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 32'h30, 5'd3);
    idle(2);

    // back-pressure fills the skid entry, then drains in order
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 32'hA, 5'd4);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 32'hB, 5'd5);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 32'hBAD, 5'd6);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 32'h0, 5'd0);
    idle(3);

    // flush with both entries full and a new input presented
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 32'h1, 5'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 32'h2, 5'd2);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 32'hC, 5'd3);
    idle(2);

    // bubble gating of a store
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 2'b10, 32'h77, 5'd9);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b10, 32'h77, 5'd9);
    idle(2);

    // forwarding candidates: rd 0 must not forward, rd 7 must
    drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 32'h55, 5'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 32'h55, 5'd7);
    idle(2);

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 9) < 6),
            2'($urandom), 2'($urandom), $urandom,
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom));
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
